control_sequencer: RTL and testbench

- Parametrised successor to the combinational control decoder.
- Owns the processor stage register, so the stage is no longer an external input.
- Adds handshaked program loading, data-memory wait states, a HALT instruction and restart/reload control.
- Sits between IR/SR and the datapath enables; drives PC, Acc, SR, IR, DR, PMem, DMem, ALU and both MUX selects.

---
 rtl/cpu_pkg.sv | 63 ++++++
 rtl/instr_class_decode.sv | 56 +++++
 rtl/control_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: stage encodings, instruction
// class opcodes and instruction field positions measured from the IR MSB.
package cpu_pkg;

    // Processor stage encodings, also exported on the stage debug port.
    typedef enum logic [2:0] {
        ST_LOAD     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXECUTE  = 3'd3,
        ST_MEM_WAIT = 3'd4,
        ST_HALT     = 3'd5
    } stage_e;

    // Bit positions inside the instruction class one-hot vector.
    localparam int CLS_IMM  = 0;
    localparam int CLS_JMP  = 1;
    localparam int CLS_MEM  = 2;
    localparam int CLS_HALT = 3;
    localparam int CLS_NOP  = 4;
    localparam int CLS_ADV  = 5;
    localparam int CLS_W    = 6;

    // Top-nibble opcode patterns; IMM matches on bit 3, JMP on [3:2],
    // MEM on [3:1], NOP/HALT and ADV on the whole nibble.
    localparam logic [3:0] OPC_IMM = 4'b1000;
    localparam logic [3:0] OPC_JMP = 4'b0100;
    localparam logic [3:0] OPC_MEM = 4'b0010;
    localparam logic [3:0] OPC_NOP = 4'b0000;
    localparam logic [3:0] OPC_ADV = 4'b0001;

    // HALT is the NOP opcode with every remaining low bit set.
    function automatic logic is_halt_tail(input logic [63:0] low_bits, input int width);
        logic all_ones;
        all_ones = 1'b1;
        for (int i = 0; i < width; i++) begin
            all_ones = all_ones & low_bits[i];
        end
        return all_ones;
    endfunction

    // Field offsets, all relative to the instruction MSB.
    function automatic int opc_lsb(input int ir_w);
        return ir_w - 32'sd4;
    endfunction

    function automatic int imm_alu_msb(input int ir_w);
        return ir_w - 32'sd2;
    endfunction

    function automatic int cond_msb(input int ir_w);
        return ir_w - 32'sd3;
    endfunction

    function automatic int wr_acc_bit(input int ir_w);
        return ir_w - 32'sd4;
    endfunction

    function automatic int mem_alu_msb(input int ir_w);
        return ir_w - 32'sd5;
    endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational instruction classifier: splits the IR into a class one-hot
// plus the ALU mode, jump condition index and accumulator-write flag.
module instr_class_decode
    import cpu_pkg::*;
#(
    parameter int IR_W       = 12,
    parameter int SR_W       = 4,
    parameter int ALU_MODE_W = 4,
    localparam int CIDX_W    = $clog2(SR_W)
) (
    input  logic [IR_W-1:0]       ir,
    output logic [CLS_W-1:0]      class_oh,
    output logic [ALU_MODE_W-1:0] alu_mode,
    output logic [CIDX_W-1:0]     cond_idx,
    output logic                  wr_acc
);

    localparam int OPC_LSB  = opc_lsb(IR_W);
    localparam int IMM_MSB  = imm_alu_msb(IR_W);
    localparam int COND_MSB = cond_msb(IR_W);
    localparam int WR_BIT   = wr_acc_bit(IR_W);
    localparam int MEM_MSB  = mem_alu_msb(IR_W);
    localparam int TAIL_W   = IR_W - 4;

    logic [3:0]  opc_s;
    logic [63:0] tail_s;

    // Classify by the top nibble, first match wins; ALU mode only for IMM/MEM.
    always_comb begin
        opc_s    = ir[OPC_LSB +: 4];
        tail_s   = 64'(ir[TAIL_W-1:0]);
        class_oh = {CLS_W{1'b0}};
        alu_mode = {ALU_MODE_W{1'b0}};
        cond_idx = ir[COND_MSB -: CIDX_W];
        wr_acc   = ir[WR_BIT];
        if (opc_s[3] == OPC_IMM[3]) begin
            class_oh[CLS_IMM] = 1'b1;
            alu_mode          = ALU_MODE_W'(ir[IMM_MSB -: 3]);
        end else if (opc_s[3:2] == OPC_JMP[3:2]) begin
            class_oh[CLS_JMP] = 1'b1;
        end else if (opc_s[3:1] == OPC_MEM[3:1]) begin
            class_oh[CLS_MEM] = 1'b1;
            alu_mode          = ALU_MODE_W'(ir[MEM_MSB -: 4]);
        end else if (opc_s == OPC_NOP) begin
            if (is_halt_tail(tail_s, TAIL_W)) begin
                class_oh[CLS_HALT] = 1'b1;
            end else begin
                class_oh[CLS_NOP] = 1'b1;
            end
        end else begin
            // Only OPC_ADV remains once the patterns above are excluded.
            class_oh[CLS_ADV] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Processor control sequencer: owns the stage register and drives the
// datapath enables/selects from the current stage and instruction class.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int IR_W       = 12,
    parameter int SR_W       = 4,
    parameter int ALU_MODE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_done,
    input  logic                  start,
    input  logic                  load_req,
    input  logic                  dmem_ready,
    input  logic [IR_W-1:0]       ir,
    input  logic [SR_W-1:0]       sr,
    output logic [2:0]            stage,
    output logic                  halted,
    output logic [ALU_MODE_W-1:0] alu_mode,
    output logic                  pc_e,
    output logic                  acc_e,
    output logic                  sr_e,
    output logic                  ir_e,
    output logic                  dr_e,
    output logic                  pmem_e,
    output logic                  pmem_le,
    output logic                  dmem_e,
    output logic                  dmem_we,
    output logic                  alu_e,
    output logic                  mux1_sel,
    output logic                  mux2_sel
);

    localparam int CIDX_W = $clog2(SR_W);

    stage_e                  state_r;
    stage_e                  next_s;
    logic [CLS_W-1:0]        class_s;
    logic [ALU_MODE_W-1:0]   dec_alu_s;
    logic [CIDX_W-1:0]       cond_idx_s;
    logic                    wr_acc_s;
    logic                    cond_s;

    instr_class_decode #(
        .IR_W       (IR_W),
        .SR_W       (SR_W),
        .ALU_MODE_W (ALU_MODE_W)
    ) u_decode (
        .ir       (ir),
        .class_oh (class_s),
        .alu_mode (dec_alu_s),
        .cond_idx (cond_idx_s),
        .wr_acc   (wr_acc_s)
    );

    assign cond_s = sr[cond_idx_s];
    assign stage  = state_r;

    // Stage register; reset aborts any instruction and returns to LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= next_s;
        end
    end

    // Next stage and datapath controls; everything idles low unless set here.
    always_comb begin
        next_s   = state_r;
        halted   = 1'b0;
        alu_mode = {ALU_MODE_W{1'b0}};
        pc_e     = 1'b0;
        acc_e    = 1'b0;
        sr_e     = 1'b0;
        ir_e     = 1'b0;
        dr_e     = 1'b0;
        pmem_e   = 1'b0;
        pmem_le  = 1'b0;
        dmem_e   = 1'b0;
        dmem_we  = 1'b0;
        alu_e    = 1'b0;
        mux1_sel = 1'b0;
        mux2_sel = 1'b0;
        case (state_r)
            ST_LOAD: begin
                pmem_e  = 1'b1;
                pmem_le = 1'b1;
                if (load_done) begin
                    next_s = ST_FETCH;
                end else begin
                    next_s = ST_LOAD;
                end
            end
            ST_FETCH: begin
                ir_e   = 1'b1;
                pmem_e = 1'b1;
                next_s = ST_DECODE;
            end
            ST_DECODE: begin
                if (class_s[CLS_MEM]) begin
                    // Data memory access starts here and stalls until ready.
                    dmem_e = 1'b1;
                    dr_e   = dmem_ready;
                    if (dmem_ready) begin
                        next_s = ST_EXECUTE;
                    end else begin
                        next_s = ST_DECODE;
                    end
                end else begin
                    next_s = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (class_s[CLS_IMM]) begin
                    pc_e     = 1'b1;
                    acc_e    = 1'b1;
                    sr_e     = 1'b1;
                    alu_e    = 1'b1;
                    mux1_sel = 1'b1;
                    mux2_sel = 1'b0;
                    alu_mode = dec_alu_s;
                    next_s   = ST_FETCH;
                end else if (class_s[CLS_JMP]) begin
                    pc_e     = 1'b1;
                    mux1_sel = cond_s;
                    next_s   = ST_FETCH;
                end else if (class_s[CLS_MEM] && wr_acc_s) begin
                    pc_e     = 1'b1;
                    acc_e    = 1'b1;
                    sr_e     = 1'b1;
                    alu_e    = 1'b1;
                    alu_mode = dec_alu_s;
                    next_s   = ST_FETCH;
                end else if (class_s[CLS_MEM]) begin
                    // Store: PC/SR only advance on the cycle the write is taken.
                    dmem_e   = 1'b1;
                    dmem_we  = 1'b1;
                    alu_e    = 1'b1;
                    alu_mode = dec_alu_s;
                    pc_e     = dmem_ready;
                    sr_e     = dmem_ready;
                    if (dmem_ready) begin
                        next_s = ST_FETCH;
                    end else begin
                        next_s = ST_MEM_WAIT;
                    end
                end else if (class_s[CLS_NOP]) begin
                    pc_e     = 1'b1;
                    mux1_sel = 1'b1;
                    next_s   = ST_FETCH;
                end else if (class_s[CLS_ADV]) begin
                    pc_e     = 1'b1;
                    mux1_sel = 1'b0;
                    next_s   = ST_FETCH;
                end else if (class_s[CLS_HALT]) begin
                    next_s = ST_HALT;
                end else begin
                    next_s = ST_LOAD;
                end
            end
            ST_MEM_WAIT: begin
                dmem_e   = 1'b1;
                dmem_we  = 1'b1;
                alu_e    = 1'b1;
                alu_mode = dec_alu_s;
                pc_e     = dmem_ready;
                sr_e     = dmem_ready;
                if (dmem_ready) begin
                    next_s = ST_FETCH;
                end else begin
                    next_s = ST_MEM_WAIT;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                if (load_req) begin
                    next_s = ST_LOAD;
                end else if (start) begin
                    next_s = ST_FETCH;
                end else begin
                    next_s = ST_HALT;
                end
            end
            default: begin
                pmem_e  = 1'b1;
                pmem_le = 1'b1;
                next_s  = ST_LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: the stimulus process drives one cycle
// at a time and queues the expected outputs; a monitor compares on negedge.
module tb_control_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_done;
    logic        start;
    logic        load_req;
    logic        dmem_ready;
    logic [11:0] ir;
    logic [3:0]  sr;
    logic [2:0]  stage;
    logic        halted;
    logic [3:0]  alu_mode;
    logic pc_e, acc_e, sr_e, ir_e, dr_e, pmem_e, pmem_le;
    logic dmem_e, dmem_we, alu_e, mux1_sel, mux2_sel;

    // Enable word bit masks: {pc,acc,sr,ir,dr,pmem,pmem_le,dmem,dmem_we,alu,mux1,mux2}
    localparam logic [11:0] E_PC   = 12'h800;
    localparam logic [11:0] E_ACC  = 12'h400;
    localparam logic [11:0] E_SR   = 12'h200;
    localparam logic [11:0] E_IR   = 12'h100;
    localparam logic [11:0] E_DR   = 12'h080;
    localparam logic [11:0] E_PMEM = 12'h040;
    localparam logic [11:0] E_PLE  = 12'h020;
    localparam logic [11:0] E_DMEM = 12'h010;
    localparam logic [11:0] E_WE   = 12'h008;
    localparam logic [11:0] E_ALU  = 12'h004;
    localparam logic [11:0] E_M1   = 12'h002;
    localparam logic [11:0] E_NONE = 12'h000;

    localparam logic [11:0] EN_LOAD  = E_PMEM | E_PLE;
    localparam logic [11:0] EN_FETCH = E_IR | E_PMEM;
    localparam logic [11:0] EN_STORE = E_DMEM | E_WE | E_ALU;

    string       name_q[$];
    logic [19:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;

    control_sequencer #(.IR_W(12), .SR_W(4), .ALU_MODE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_done  (load_done),
        .start      (start),
        .load_req   (load_req),
        .dmem_ready (dmem_ready),
        .ir         (ir),
        .sr         (sr),
        .stage      (stage),
        .halted     (halted),
        .alu_mode   (alu_mode),
        .pc_e       (pc_e),
        .acc_e      (acc_e),
        .sr_e       (sr_e),
        .ir_e       (ir_e),
        .dr_e       (dr_e),
        .pmem_e     (pmem_e),
        .pmem_le    (pmem_le),
        .dmem_e     (dmem_e),
        .dmem_we    (dmem_we),
        .alu_e      (alu_e),
        .mux1_sel   (mux1_sel),
        .mux2_sel   (mux2_sel)
    );

    always #5 clk = ~clk;

    // Queue the expected outputs for the current cycle, then advance one edge.
    task automatic cyc(input string nm, input logic [2:0] st, input logic h,
                       input logic [3:0] am, input logic [11:0] en);
        name_q.push_back(nm);
        exp_q.push_back({st, h, am, en});
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        logic [19:0] act;
        logic [19:0] exp_v;
        string       nm;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act   = {stage, halted, alu_mode, pc_e, acc_e, sr_e, ir_e, dr_e, pmem_e,
                     pmem_le, dmem_e, dmem_we, alu_e, mux1_sel, mux2_sel};
            tests++;
            if (act !== exp_v) begin
                fails++;
                $display("FAIL %s: got stage=%0d halted=%b alu_mode=%h en=%b, expected stage=%0d halted=%b alu_mode=%h en=%b",
                         nm, act[19:17], act[16], act[15:12], act[11:0],
                         exp_v[19:17], exp_v[16], exp_v[15:12], exp_v[11:0]);
            end
        end
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus with hand-computed per-cycle expectations.
    initial begin
        rst_n = 1'b0; load_done = 1'b0; start = 1'b0; load_req = 1'b0;
        dmem_ready = 1'b0; ir = 12'h000; sr = 4'b0000;
        @(posedge clk);
        #1;

        // Reset and program load
        cyc("reset", ST_LOAD, 1'b0, 4'h0, EN_LOAD);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc("load_wait", ST_LOAD, 1'b0, 4'h0, EN_LOAD);
        load_done = 1'b1;
        cyc("load_done", ST_LOAD, 1'b0, 4'h0, EN_LOAD);
        load_done = 1'b0;

        // IMM 12'hA05: FETCH -> DECODE -> EXECUTE, alu_mode 2
        ir = 12'hA05;
        cyc("imm_fetch", ST_FETCH, 1'b0, 4'h0, EN_FETCH);
        cyc("imm_decode", ST_DECODE, 1'b0, 4'h0, E_NONE);
        cyc("imm_exec", ST_EXECUTE, 1'b0, 4'h2, E_PC | E_ACC | E_SR | E_ALU | E_M1);

        // MEM read 12'h330 (wr_acc=1, alu_mode 3) with 3 stall cycles
        ir = 12'h330;
        cyc("rd_fetch", ST_FETCH, 1'b0, 4'h0, EN_FETCH);
        for (int i = 0; i < 3; i++) cyc("rd_stall", ST_DECODE, 1'b0, 4'h0, E_DMEM);
        dmem_ready = 1'b1;
        cyc("rd_ready", ST_DECODE, 1'b0, 4'h0, E_DMEM | E_DR);
        dmem_ready = 1'b0;
        cyc("rd_exec", ST_EXECUTE, 1'b0, 4'h3, E_PC | E_ACC | E_SR | E_ALU);

        // Store 12'h250 (wr_acc=0, alu_mode 5), ready on 2nd MEM_WAIT cycle
        ir = 12'h250;
        cyc("st_fetch", ST_FETCH, 1'b0, 4'h0, EN_FETCH);
        dmem_ready = 1'b1;
        cyc("st_decode", ST_DECODE, 1'b0, 4'h0, E_DMEM | E_DR);
        dmem_ready = 1'b0;
        cyc("st_exec", ST_EXECUTE, 1'b0, 4'h5, EN_STORE);
        cyc("st_wait1", ST_MEM_WAIT, 1'b0, 4'h5, EN_STORE);
        dmem_ready = 1'b1;
        cyc("st_wait2", ST_MEM_WAIT, 1'b0, 4'h5, EN_STORE | E_PC | E_SR);
        dmem_ready = 1'b0;

        // Jump 12'h500 tests sr[1]: taken then not taken
        ir = 12'h500; sr = 4'b0010;
        cyc("jt_fetch", ST_FETCH, 1'b0, 4'h0, EN_FETCH);
        cyc("jt_decode", ST_DECODE, 1'b0, 4'h0, E_NONE);
        cyc("jt_exec", ST_EXECUTE, 1'b0, 4'h0, E_PC | E_M1);
        sr = 4'b0000;
        cyc("jn_fetch", ST_FETCH, 1'b0, 4'h0, EN_FETCH);
        cyc("jn_decode", ST_DECODE, 1'b0, 4'h0, E_NONE);
        cyc("jn_exec", ST_EXECUTE, 1'b0, 4'h0, E_PC);

        // ADV 12'h100 then NOP 12'h000
        ir = 12'h100;
        cyc("adv_fetch", ST_FETCH, 1'b0, 4'h0, EN_FETCH);
        cyc("adv_decode", ST_DECODE, 1'b0, 4'h0, E_NONE);
        cyc("adv_exec", ST_EXECUTE, 1'b0, 4'h0, E_PC);
        ir = 12'h000;
        cyc("nop_fetch", ST_FETCH, 1'b0, 4'h0, EN_FETCH);
        cyc("nop_decode", ST_DECODE, 1'b0, 4'h0, E_NONE);
        cyc("nop_exec", ST_EXECUTE, 1'b0, 4'h0, E_PC | E_M1);

        // HALT 12'h0FF, then start+load_req together -> LOAD
        ir = 12'h0FF;
        cyc("hlt_fetch", ST_FETCH, 1'b0, 4'h0, EN_FETCH);
        cyc("hlt_decode", ST_DECODE, 1'b0, 4'h0, E_NONE);
        cyc("hlt_exec", ST_EXECUTE, 1'b0, 4'h0, E_NONE);
        cyc("halted1", ST_HALT, 1'b1, 4'h0, E_NONE);
        cyc("halted2", ST_HALT, 1'b1, 4'h0, E_NONE);
        start = 1'b1; load_req = 1'b1;
        cyc("halt_both", ST_HALT, 1'b1, 4'h0, E_NONE);
        start = 1'b0; load_req = 1'b0; load_done = 1'b1;
        cyc("reload", ST_LOAD, 1'b0, 4'h0, EN_LOAD);
        load_done = 1'b0;

        // HALT again, start alone -> FETCH
        cyc("hlt2_fetch", ST_FETCH, 1'b0, 4'h0, EN_FETCH);
        cyc("hlt2_decode", ST_DECODE, 1'b0, 4'h0, E_NONE);
        cyc("hlt2_exec", ST_EXECUTE, 1'b0, 4'h0, E_NONE);
        start = 1'b1;
        cyc("halt_start", ST_HALT, 1'b1, 4'h0, E_NONE);
        start = 1'b0;

        // Store stuck in MEM_WAIT, reset asserted mid-cycle
        ir = 12'h250;
        cyc("rs_fetch", ST_FETCH, 1'b0, 4'h0, EN_FETCH);
        dmem_ready = 1'b1;
        cyc("rs_decode", ST_DECODE, 1'b0, 4'h0, E_DMEM | E_DR);
        dmem_ready = 1'b0;
        cyc("rs_exec", ST_EXECUTE, 1'b0, 4'h5, EN_STORE);
        cyc("rs_wait", ST_MEM_WAIT, 1'b0, 4'h5, EN_STORE);
        #1;
        rst_n = 1'b0;
        cyc("rs_abort", ST_LOAD, 1'b0, 4'h0, EN_LOAD);
        rst_n = 1'b1;
        cyc("rs_after", ST_LOAD, 1'b0, 4'h0, EN_LOAD);

        // Let the monitor drain any outstanding expectation (bounded).
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
